// File: rtl/pcs_efifo12_pkg.sv
// Shared definitions for the 12-entry PCS elastic FIFO: depth, 12-code Gray
// sequence and index/Gray conversion helpers used by both pointer domains.
package pcs_efifo12_pkg;

  localparam int EFIFO_DEPTH = 12;
  localparam logic [3:0] EFIFO_LAST = 4'd11;

  localparam logic [3:0] GRAY12 [EFIFO_DEPTH] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
    4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1001, 4'b1000
  };

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } gray_dec_t;

  // The four codes outside the sequence decode with valid = 0.
  function automatic gray_dec_t gray12_to_idx(input logic [3:0] g);
    gray_dec_t r;
    r = '0;
    for (int i = 0; i < EFIFO_DEPTH; i++) begin
      if (g == GRAY12[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] idx_to_gray12(input logic [3:0] idx);
    logic [3:0] g;
    g = 4'b0000;
    if (idx <= EFIFO_LAST) g = GRAY12[idx];
    return g;
  endfunction

endpackage

// File: rtl/pcs_sync_vec.sv
// Generic multi-flop synchronizer for a Gray-coded pointer vector.
// Output is the last stage; all stages clear on synchronous reset.
module pcs_sync_vec #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pcs_efifo12_rd_ctrl.sv
// Read-side controller of the 12-entry dual-clock elastic FIFO: synchronizes the
// write pointer, drains the RAM into a registered valid/ready stage, returns rd_ptr_gray.
module pcs_efifo12_rd_ctrl
  import pcs_efifo12_pkg::*;
#(
  parameter int DATA_W      = 66,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        wr_ptr_gray,
  input  logic [DATA_W-1:0] rd_data,
  output logic [3:0]        rd_addr,
  output logic [3:0]        rd_ptr_gray,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [3:0]        level,
  output logic              empty,
  output logic              err_illegal
);

  logic [3:0] wr_sync;
  logic [3:0] wr_idx_q;
  logic [3:0] wr_idx;
  logic [3:0] rd_idx;
  logic [3:0] rd_idx_nxt;
  logic [4:0] level_w;
  logic       pop;
  gray_dec_t  wr_dec;

  pcs_sync_vec #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (4)
  ) u_wr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (wr_ptr_gray),
    .q       (wr_sync)
  );

  // An illegal code keeps the last good write index so occupancy never jumps.
  assign wr_dec = gray12_to_idx(wr_sync);
  assign wr_idx = wr_dec.valid ? wr_dec.idx : wr_idx_q;

  always_comb begin
    level_w = 5'd0;
    if (wr_idx >= rd_idx) level_w = {1'b0, wr_idx} - {1'b0, rd_idx};
    else                  level_w = {1'b0, wr_idx} + 5'd12 - {1'b0, rd_idx};
  end

  assign level      = level_w[3:0];
  assign empty      = (level_w == 5'd0);
  assign pop        = !empty && (!dout_valid || dout_ready);
  assign rd_idx_nxt = (rd_idx == EFIFO_LAST) ? 4'd0 : rd_idx + 4'd1;
  assign rd_addr    = rd_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_idx_q    <= 4'd0;
      rd_idx      <= 4'd0;
      rd_ptr_gray <= 4'b0000;
      dout        <= '0;
      dout_valid  <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx;
      if (!wr_dec.valid) err_illegal <= 1'b1;
      if (pop) begin
        dout        <= rd_data;
        dout_valid  <= 1'b1;
        rd_idx      <= rd_idx_nxt;
        rd_ptr_gray <= idx_to_gray12(rd_idx_nxt);
      end else if (dout_ready) begin
        dout_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcs_efifo12_rd_ctrl.sv
// Scoreboard bench for pcs_efifo12_rd_ctrl: a behavioural write side fills a
// RAM model and an expected queue; a monitor compares every accepted dout.
module tb_pcs_efifo12_rd_ctrl;

  localparam int DW = 66;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    wr_ptr_gray = 4'b0000;
  logic [DW-1:0] rd_data;
  logic [3:0]    rd_addr;
  logic [3:0]    rd_ptr_gray;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [3:0]    level;
  logic          empty;
  logic          err_illegal;

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:15];
  always_comb rd_data = ram[rd_addr];

  pcs_efifo12_rd_ctrl #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_data     (rd_data),
    .rd_addr     (rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .level       (level),
    .empty       (empty),
    .err_illegal (err_illegal)
  );

  logic [3:0] gray_tab [0:11] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
    4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1001, 4'b1000
  };

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];
  int            wr_total = 0;
  int            acc_total = 0;
  int            rd_seen = 0;
  logic [3:0]    last_rd_gray = 4'b0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Write side: store the entry, then advance the Gray pointer past it.
  task automatic write_entry(input logic [DW-1:0] d);
    ram[4'(wr_total % 12)] = d;
    exp_q.push_back(d);
    wr_total++;
    wr_ptr_gray = gray_tab[4'(wr_total % 12)];
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    dout_ready = 1'b1;
    while (exp_q.size() != 0 && i < budget) begin
      tick();
      i++;
    end
    chk("drain_done", 32'(exp_q.size()), 0);
    tick();
    chk("drain_level", 32'(level), 0);
    chk("drain_valid", 32'(dout_valid), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dout_unexpected: got %0h expected no transfer at %0t", dout, $time);
        end else begin
          chk_d("dout", dout, exp_q.pop_front());
        end
        acc_total++;
      end
      if (rd_ptr_gray !== last_rd_gray) begin
        chk("rd_ptr_step", 32'(rd_ptr_gray), 32'(gray_tab[4'((rd_seen + 1) % 12)]));
        rd_seen      = (rd_seen + 1) % 12;
        last_rd_gray = rd_ptr_gray;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int start_idx;
    logic [3:0] saved_gray;

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_rd_ptr", 32'(rd_ptr_gray), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_err", 32'(err_illegal), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    reset_n = 1'b1;
    tick();

    // Single write: latency from pointer step to dout_valid
    dout_ready = 1'b0;
    write_entry(rand_data());
    tick();
    tick();
    chk("single_lat_early", 32'(dout_valid), 0);
    tick();
    chk("single_valid", 32'(dout_valid), 1);
    chk_d("single_dout", dout, exp_q[0]);
    chk("single_rd_ptr", 32'(rd_ptr_gray), 32'(gray_tab[1]));
    chk("single_level", 32'(level), 0);
    chk("single_empty", 32'(empty), 1);
    drain(20);

    // Full wrap, twice around the ring with the sink always ready
    dout_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      write_entry(rand_data());
      tick();
    end
    drain(50);
    chk("wrap_acc", 32'(acc_total), 25);
    chk("wrap_rd_ptr", 32'(rd_ptr_gray), 32'(gray_tab[4'(wr_total % 12)]));
    chk("wrap_err", 32'(err_illegal), 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      if ((wr_total - acc_total) < 11 && $urandom_range(0, 1) == 1) write_entry(rand_data());
      tick();
    end
    drain(100);

    // Backpressure: five entries, sink stalled
    dout_ready = 1'b0;
    start_idx  = wr_total % 12;
    for (int i = 0; i < 5; i++) begin
      write_entry(rand_data());
      tick();
    end
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_level", 32'(level), 4);
      chk("bp_valid", 32'(dout_valid), 1);
      chk_d("bp_dout_hold", dout, exp_q[0]);
      chk("bp_rd_addr", 32'(rd_addr), 32'((start_idx + 1) % 12));
      tick();
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_burst_valid", 32'(dout_valid), 1);
    end
    @(negedge clk);
    chk("bp_burst_end", 32'(dout_valid), 0);
    tick();
    chk("bp_queue", 32'(exp_q.size()), 0);

    // Illegal Gray code on the write pointer
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write_entry(rand_data());
      tick();
    end
    tick();
    tick();
    chk("ill_level_before", 32'(level), 2);
    saved_gray  = wr_ptr_gray;
    wr_ptr_gray = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ill_level_hold", 32'(level), 2);
    end
    wr_ptr_gray = saved_gray;
    tick();
    tick();
    tick();
    chk("ill_err_set", 32'(err_illegal), 1);
    chk("ill_level_after", 32'(level), 2);
    drain(30);
    chk("ill_err_sticky", 32'(err_illegal), 1);

    // Reset in the middle of a drain
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      write_entry(rand_data());
      tick();
    end
    tick();
    tick();
    chk("mid_level", 32'(level), 7);
    chk("mid_valid", 32'(dout_valid), 1);
    reset_n     = 1'b0;
    wr_ptr_gray = 4'b0000;
    tick();
    chk("mid_rst_valid", 32'(dout_valid), 0);
    chk("mid_rst_rd_ptr", 32'(rd_ptr_gray), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_err", 32'(err_illegal), 0);
    exp_q.delete();
    wr_total     = 0;
    acc_total    = 0;
    rd_seen      = 0;
    last_rd_gray = 4'b0000;
    reset_n      = 1'b1;
    tick();

    // Traffic resumes cleanly after reset
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write_entry(rand_data());
      tick();
    end
    drain(20);
    chk("post_rst_acc", 32'(acc_total), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcs_efifo12_rd_ctrl.md
# pcs_efifo12_rd_ctrl

Read-side controller of the 12-entry dual-clock elastic FIFO in the 25G PCS receive path. It takes the write-domain 12-code Gray write pointer and brings it into clk with a synchronizer. It decodes that pointer, compares it with its own read pointer, and drains the external 12-entry RAM into a registered valid/ready output stage. It also returns its own 12-code Gray read pointer to the write domain for full detection.

## Interface
- DATA_W, 66, width of one FIFO entry (one 64b/66b block)
- SYNC_STAGES, 2, flops in the write-pointer synchronizer; legal values ≥ 2
- clk  in  1  read-domain clock
- reset_n  in  1  reset, synchronous, active-low; clock clk
- wr_ptr_gray  in  4  write pointer, 12-code Gray, asynchronous to clk
- rd_data  in  DATA_W  RAM read data; combinational from rd_addr
- rd_addr  out  4  binary read index 0..11 to the RAM
- rd_ptr_gray  out  4  registered 12-code Gray read pointer, sent to the write domain
- dout  out  DATA_W  output entry
- dout_valid  out  1  dout holds an unconsumed entry
- dout_ready  in  1  downstream accepts dout when high together with dout_valid
- level  out  4  entries in the RAM not yet popped, 0..11
- empty  out  1  level == 0
- err_illegal  out  1  sticky; a non-sequence Gray code was seen on the synchronized write pointer

## Operation
- Gray sequence, index 0..11: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1001, 1000. Index 11 wraps to index 0.
- Synchronizer: SYNC_STAGES flops on wr_ptr_gray; the last stage is wr_sync.
- Decode: wr_sync is decoded to wr_idx. If wr_sync is any of the 4 unused codes, wr_idx holds its previous value and err_illegal sets. err_illegal clears only on reset.
- Read state: rd_idx (0..11), with rd_ptr_gray registered as the Gray encoding of rd_idx. rd_addr = rd_idx.
- Occupancy: level = (wr_idx ≥ rd_idx) ? wr_idx − rd_idx : wr_idx + 12 − rd_idx. Computed in 5 bits, output as 4 bits. empty = (level == 0).
- Pop condition: pop = !empty && (!dout_valid || dout_ready).
- On pop:
  - dout ← rd_data
  - dout_valid ← 1
  - rd_idx ← (rd_idx == 11) ? 0 : rd_idx + 1
  - rd_ptr_gray ← Gray of the new rd_idx
- When dout_valid && dout_ready && !pop: dout_valid ← 0. dout keeps its value.
- When dout_valid && !dout_ready: dout and dout_valid hold, and no pop occurs (backpressure).
- Simultaneous accept and non-empty: the next entry loads in the same cycle, so throughput is 1 entry per clk.
- Reset values:
  - rd_idx = 0, rd_ptr_gray = 0000
  - all synchronizer flops = 0000, wr_idx = 0
  - dout = 0, dout_valid = 0, err_illegal = 0
  - so level = 0 and empty = 1
- Reset mid-operation: all state clears on the next edge, and any held dout is discarded. The write side is reset by the same system reset event. No attempt is made to preserve entries.

## Timing
- A wr_ptr_gray value stable before edge k appears at wr_sync after edge k+SYNC_STAGES−1.
- The pop decision uses that wr_sync value combinationally.
- For SYNC_STAGES=2, with the FIFO empty and dout_valid=0: a write-pointer step sampled at edge k gives dout_valid=1 after edge k+2.
- rd_ptr_gray changes one cycle after the pop decision and only by single-bit steps. It is registered, with no combinational path to the output.
- rd_data must settle within one clk of an rd_addr change.

## Structure
- Shared package pcs_efifo12_pkg holds:
  - EFIFO_DEPTH = 12
  - the 12 Gray code constants
  - functions gray12_to_idx (returning a valid flag) and idx_to_gray12
- The write-side controller uses the same package.
- One sub-module: pcs_sync_vec, a generic SYNC_STAGES × width flop synchronizer, reused for the write-domain copy of rd_ptr_gray.

## Test plan
- Reset check: after reset_n low for 2 cycles, expect rd_ptr_gray=0000, dout_valid=0, level=0, empty=1, err_illegal=0.
- Single write: drive wr_ptr_gray 0000→0001 with rd_data=A and dout_ready=0.
  - Expect dout_valid=1, dout=A after 2 edges (SYNC_STAGES=2).
  - Expect rd_ptr_gray=0001, level=0.
- Full wrap: step wr_ptr_gray through all 12 codes and back to 0000, twice, with dout_ready=1.
  - Expect 24 pops with dout in order.
  - rd_ptr_gray follows the sequence 1000→0000 at the wrap.
  - err_illegal stays 0.
- Backpressure: preload 5 entries (wr at index 5), hold dout_ready=0 for 10 cycles.
  - Expect dout stable, level=4, rd_idx=1 throughout.
  - On release with dout_ready=1, expect 5 transfers in 5 consecutive cycles.
- Illegal code: force wr_ptr_gray=1111 for 3 cycles.
  - Expect err_illegal=1 sticky and level unchanged from before.
  - Expect err_illegal=1 to persist until reset.
- Reset mid-drain: assert reset_n low with level=7 and dout_valid=1.
  - On the next edge, expect dout_valid=0, rd_ptr_gray=0000, level=0.
